// File: rtl/evm_pkg.sv
// evm_pkg: poll state encoding and shared helpers for the vote tally.
package evm_pkg;
    localparam int MAX_CAND = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ARMED = 2'd2, CLOSED = 2'd3} state_t;
    function automatic logic onehot_check(logic [MAX_CAND-1:0] v);
        return v != '0 && (v & (v - 1'b1)) == '0;
    endfunction
    function automatic logic [31:0] sat_inc(logic [31:0] v, logic [31:0] max);
        return v == max ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/vote_tally_if.sv
// vote_tally_if: officer/voter controls and tally readout of the vote counter.
interface vote_tally_if #(
    parameter int NUM_CAND = 4,
    parameter int COUNT_W = 8,
    parameter int TOTAL_W = COUNT_W + 4,
    parameter int IDX_W = 4
);
    logic poll_open;
    logic poll_close;
    logic ballot_arm;
    logic vote_valid;
    logic [NUM_CAND-1:0] vote_in;
    logic [IDX_W-1:0] rd_idx;
    logic [COUNT_W-1:0] rd_count;
    logic [TOTAL_W-1:0] total_count;
    logic [TOTAL_W-1:0] reject_count;
    logic vote_ack;
    logic vote_reject;
    logic [NUM_CAND-1:0] sat_flag;
    logic armed;
    logic closed;
    modport master (
        output poll_open, poll_close, ballot_arm, vote_valid, vote_in, rd_idx,
        input rd_count, total_count, reject_count, vote_ack, vote_reject, sat_flag, armed, closed
    );
    modport slave (
        input poll_open, poll_close, ballot_arm, vote_valid, vote_in, rd_idx,
        output rd_count, total_count, reject_count, vote_ack, vote_reject, sat_flag, armed, closed
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
module sat_counter
    import evm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_max
);
    localparam logic [W-1:0] MAX = '1;
    always_ff @(posedge clock)
        if (reset) count <= '0;
        else if (inc) count <= W'(sat_inc(32'(count), 32'(MAX)));
    assign at_max = count == MAX;
endmodule

// File: rtl/vote_tally.sv
// vote_tally: poll-controlled N-candidate vote counter with saturating tallies
// and a registered indexed readout.
module vote_tally
    import evm_pkg::*;
#(
    parameter int NUM_CAND = 4,
    parameter int COUNT_W = 8,
    parameter int TOTAL_W = COUNT_W + 4,
    parameter int IDX_W = 4
) (
    input logic         clock,
    input logic         reset,
    vote_tally_if.slave bus
);
    state_t state, next;
    logic acc, rej, total_max, reject_max;
    logic [NUM_CAND-1:0] at_max;
    logic [NUM_CAND-1:0][COUNT_W-1:0] counts;
    logic [COUNT_W-1:0] rd_mux;
    always_ff @(posedge clock)
        state <= reset ? IDLE : next;
    always_comb begin
        next = state;
        acc = 1'b0;
        rej = 1'b0;
        case (state)
            IDLE: next = bus.poll_open ? WAIT : IDLE;
            WAIT: begin
                rej = bus.vote_valid;
                next = bus.poll_close ? CLOSED : bus.ballot_arm ? ARMED : WAIT;
            end
            ARMED: begin
                acc = bus.vote_valid && onehot_check(MAX_CAND'(bus.vote_in));
                rej = bus.vote_valid && !onehot_check(MAX_CAND'(bus.vote_in));
                next = bus.poll_close ? CLOSED : acc ? WAIT : ARMED;
            end
            default: next = CLOSED;
        endcase
    end
    for (genvar g = 0; g < NUM_CAND; g++) begin : g_cand
        sat_counter #(.W(COUNT_W)) u_cnt (
            .clock(clock), .reset(reset), .inc(acc && bus.vote_in[g]),
            .count(counts[g]), .at_max(at_max[g])
        );
    end
    // Tallies stop requesting increments once pinned at max.
    sat_counter #(.W(TOTAL_W)) u_total (
        .clock(clock), .reset(reset), .inc(acc && !total_max),
        .count(bus.total_count), .at_max(total_max)
    );
    sat_counter #(.W(TOTAL_W)) u_reject (
        .clock(clock), .reset(reset), .inc(rej && !reject_max),
        .count(bus.reject_count), .at_max(reject_max)
    );
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CAND; i++)
            if (bus.rd_idx == IDX_W'(i)) rd_mux = counts[i];
    end
    always_ff @(posedge clock)
        if (reset) begin
            bus.rd_count <= '0;
            bus.vote_ack <= 1'b0;
            bus.vote_reject <= 1'b0;
        end else begin
            bus.rd_count <= rd_mux;
            bus.vote_ack <= acc;
            bus.vote_reject <= rej;
        end
    assign bus.sat_flag = at_max;
    assign bus.armed = state == ARMED;
    assign bus.closed = state == CLOSED;
endmodule

// File: doc/vote_tally.md
Name: vote_tally

Overview:
- Parametrised successor to the fixed 4-candidate, 8-bit vote counter.
- Supports N candidates, configurable count width, saturating counters and a poll-control state machine (open / arm / vote / close).
- Enforces one vote per armed ballot, rejects malformed or unarmed votes, keeps total and reject tallies, and exposes an indexed registered readout for the result display.

Parameters:
- NUM_CAND, 4, number of candidates (2..16)
- COUNT_W, 8, width of each per-candidate counter
- TOTAL_W, COUNT_W+4, width of the total and reject counters
- IDX_W, 4, width of rd_idx; must satisfy 2^IDX_W >= NUM_CAND

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- poll_open  in  1  officer pulse: open poll
- poll_close  in  1  officer pulse: close poll (irreversible until reset)
- ballot_arm  in  1  officer pulse: issue one ballot
- vote_valid  in  1  voter strobe, one cycle
- vote_in  in  NUM_CAND  candidate select; must be one-hot
- rd_idx  in  IDX_W  readout candidate index
- rd_count  out  COUNT_W  count of candidate rd_idx
- total_count  out  TOTAL_W  accepted votes
- reject_count  out  TOTAL_W  rejected strobes
- vote_ack  out  1  pulse: vote accepted
- vote_reject  out  1  pulse: strobe rejected
- sat_flag  out  NUM_CAND  sticky per-candidate saturation flag
- armed  out  1  ballot armed, ready for voter
- closed  out  1  poll closed

Behaviour:
- Reset values (synchronous reset, any state):
  - all counters 0, rd_count 0, sat_flag 0, pulses 0;
  - state IDLE, so armed=0 and closed=0;
  - a reset mid-ballot discards the ballot.
- IDLE:
  - poll_open -> WAIT.
  - All other inputs are ignored; no reject is counted.
- WAIT:
  - ballot_arm -> ARMED.
  - vote_valid -> reject (unarmed attempt).
  - poll_close -> CLOSED; poll_close has priority over ballot_arm.
  - vote_valid together with poll_close is still counted as a reject.
- ARMED:
  - vote_valid with one-hot vote_in: increment that candidate's counter and total_count, assert vote_ack, -> WAIT.
  - vote_valid with vote_in zero or multi-hot: reject, stay ARMED (voter may retry).
  - ballot_arm is ignored.
  - poll_close -> CLOSED and the ballot is cancelled.
  - If vote_valid coincides with poll_close, the vote is processed (accepted or rejected) in that cycle, then the state goes to CLOSED.
- CLOSED: terminal until reset. All inputs except rd_idx are ignored; counters are frozen.
- Rejects: increment reject_count and assert vote_reject.
- Pulse timing: vote_ack and vote_reject are registered, high for exactly one cycle, in the cycle after the strobe. They are never both high.
- Counter saturation:
  - Candidate counters saturate at 2^COUNT_W-1. A vote into a saturated counter is still acked and still added to total_count.
  - sat_flag[i] is set on the cycle the counter reaches max and stays set until reset.
  - total_count and reject_count also saturate at 2^TOTAL_W-1.
- Readout:
  - rd_count is registered: it reflects rd_idx sampled one cycle earlier and the counter value as of that edge.
  - rd_idx >= NUM_CAND reads 0.
  - Readout works in every state.
- armed = (state==ARMED) and closed = (state==CLOSED). Both are decoded from the state register, so they are glitch-free.

Decomposition:
- Package evm_pkg:
  - state enum IDLE=2'd0, WAIT=2'd1, ARMED=2'd2, CLOSED=2'd3;
  - onehot_check function (exactly one bit set);
  - saturating-increment function.
- Sub-module sat_counter: parameter W; ports clock, reset, inc, count, at_max. It is instantiated NUM_CAND times plus once each for total and reject.
- The FSM and readout mux live in the top module.

Test Plan:
- reset; poll_open; ballot_arm; vote_valid with vote_in=4'b0100 -> vote_ack next cycle; count[2]=1, total=1, back in WAIT.
- In WAIT, vote_valid with 4'b0001 (no arm) -> vote_reject, reject_count=1, all counts 0. Then arm, vote_in=4'b0011 -> reject_count=2, still armed. Then 4'b0010 -> count[1]=1.
- COUNT_W=3: 8 armed votes for candidate 0 -> count[0]=7 with sat_flag[0]=1 after the 7th vote. The 8th vote is acked, total=8, count[0] stays 7.
- ARMED with vote_valid=4'b1000 and poll_close in the same cycle -> count[3]=1, closed=1. A further poll_open, ballot_arm or vote_valid changes nothing; readout still returns count[3]=1.
- rd_idx sweep 0..NUM_CAND+1 after a known tally -> rd_count matches with 1-cycle latency; out-of-range indices read 0.
- Reset asserted while ARMED with counts nonzero -> next cycle all counts, flags and pulses are 0, state IDLE, armed=0.
